// File: rtl/axis_pkt_loopback_fifo.sv
// rtl/axis_pkt_loopback_fifo.sv - store-and-forward AXI-Stream packet loopback FIFO
// Optional packet statistics counters are built when LOOPBACK_STATS_EN is defined.
module axis_pkt_loopback_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  bd_fclk0_125m,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   pkt_count,
    output logic                  drop_pulse,
    output logic [31:0]           stat_pkts_in,
    output logic [31:0]           stat_pkts_drop
);
    localparam int KW = DATA_W / 8;
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int MW = KW + 1 + DATA_W;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0] ONE   = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_t;

    wstate_t         w_state_q, w_state_d;
    logic [MW-1:0]   mem [0:(1<<DEPTH_LOG2)-1];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
    logic [PW-1:0]   rd_ptr_q, rel_ptr_q, free_ptr_q, pkt_count_q;
    logic            rdy_en_q, drop_q, drop_d;
    logic            full, s_ready, wr_en, commit;
    logic [MW-1:0]   ram_q, out_q, out_d, skid_q, skid_d;
    logic            rd_vld_q, out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic            pop, done, issue;
    logic [1:0]      held;

    // Space is only released when a whole packet has left, so prefetched words still count as used.
    assign full = (wr_ptr_q - free_ptr_q) == DEPTH;

    always_comb begin
        w_state_d   = w_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        s_ready     = 1'b0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        drop_d      = 1'b0;
        if (rdy_en_q) begin
            case (w_state_q)
                W_IDLE, W_STORE: begin
                    if (!(full && (pkt_count_q != '0))) begin
                        s_ready = 1'b1;
                        if (s_axis_tvalid) begin
                            if (full) begin
                                // Current packet alone fills the buffer: it can never fit.
                                wr_ptr_d  = wr_commit_q;
                                w_state_d = s_axis_tlast ? W_IDLE : W_DROP;
                                drop_d    = s_axis_tlast;
                            end else begin
                                wr_en     = 1'b1;
                                wr_ptr_d  = wr_ptr_q + ONE;
                                w_state_d = W_STORE;
                                if (s_axis_tlast) begin
                                    commit      = 1'b1;
                                    wr_commit_d = wr_ptr_q + ONE;
                                    w_state_d   = W_IDLE;
                                end
                            end
                        end
                    end
                end
                W_DROP: begin
                    s_ready  = 1'b1;
                    wr_ptr_d = wr_commit_q;
                    if (s_axis_tvalid && s_axis_tlast) begin
                        drop_d    = 1'b1;
                        w_state_d = W_IDLE;
                    end
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    assign pop   = out_vld_q && m_axis_tready;
    assign done  = pop && out_q[DATA_W];
    assign held  = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
    // Two words of credit (output + skid) keep 1 word/cycle with a registered RAM read.
    assign issue = (rd_ptr_q != wr_commit_q) && ((held - {1'b0, pop}) < 2'd2);

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (pop || !out_vld_q) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = rd_vld_q;
                if (rd_vld_q) skid_d = ram_q;
            end else begin
                out_vld_d = rd_vld_q;
                if (rd_vld_q) out_d = ram_q;
            end
        end else if (rd_vld_q) begin
            skid_d     = ram_q;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge bd_fclk0_125m) begin
        if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s_axis_tkeep, s_axis_tlast, s_axis_tdata};
        if (issue) ram_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge bd_fclk0_125m) begin
        if (!resetn) begin
            w_state_q   <= W_IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            rel_ptr_q   <= '0;
            free_ptr_q  <= '0;
            pkt_count_q <= '0;
            rdy_en_q    <= 1'b0;
            drop_q      <= 1'b0;
            rd_vld_q    <= 1'b0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rdy_en_q    <= 1'b1;
            drop_q      <= drop_d;
            rd_vld_q    <= issue;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            if (issue) rd_ptr_q <= rd_ptr_q + ONE;
            if (pop) rel_ptr_q <= rel_ptr_q + ONE;
            if (done) free_ptr_q <= rel_ptr_q + ONE;
            if (commit && !done) pkt_count_q <= pkt_count_q + ONE;
            else if (done && !commit) pkt_count_q <= pkt_count_q - ONE;
        end
    end

`ifdef LOOPBACK_STATS_EN
    logic [31:0] stat_in_q, stat_drop_q;

    always_ff @(posedge bd_fclk0_125m) begin
        if (!resetn) begin
            stat_in_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            if (commit) stat_in_q <= stat_in_q + 32'd1;
            if (drop_q) stat_drop_q <= stat_drop_q + 32'd1;
        end
    end

    assign stat_pkts_in   = stat_in_q;
    assign stat_pkts_drop = stat_drop_q;
`else
    assign stat_pkts_in   = '0;
    assign stat_pkts_drop = '0;
`endif

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_q[DATA_W-1:0];
    assign m_axis_tlast  = out_q[DATA_W];
    assign m_axis_tkeep  = out_q[MW-1 -: KW];
    assign pkt_count     = pkt_count_q;
    assign drop_pulse    = drop_q;
endmodule
